// File: rtl/mem_wb_stage_if.sv
// Data-memory request/ready port between the MEM stage and data memory.
interface mem_wb_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ready, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, rdata
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access stage plus MEM/WB pipeline register. Issues data-memory
// requests, stalls upstream while memory is busy, aborts misaligned or
// timed-out accesses (sticky error), and forwards write-back data into
// store data.
module mem_wb_stage #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  EX_MEM_MemRead,
    input  logic                  EX_MEM_MemWrite,
    input  logic [1:0]            EX_MEM_MemtoReg,
    input  logic                  EX_MEM_RegWrite,
    input  logic [31:0]           EX_MEM_ALUOut,
    input  logic [31:0]           EX_MEM_PC_add4,
    input  logic [4:0]            EX_MEM_RegWrAddr,
    input  logic [31:0]           EX_MEM_WriteData,
    input  logic [4:0]            EX_MEM_Rt,
    mem_wb_stage_if.master        dmem,
    output logic                  Mem_Stall,
    output logic                  Mem_Error,
    output logic                  MEM_WB_RegWrite,
    output logic [4:0]            MEM_WB_RegWrAddr,
    output logic [31:0]           MEM_WB_WriteBackData
);

    localparam int CNT_W = ($clog2(MAX_WAIT + 1) > 5) ? $clog2(MAX_WAIT + 1) : 5;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              mem_error_q, mem_error_d;
    logic              wb_we_q, wb_we_d;
    logic [4:0]        wb_addr_q, wb_addr_d;
    logic [31:0]       wb_data_q, wb_data_d;

    logic              access;
    logic              misaligned;
    logic              abort;
    logic              req;
    logic              stall;
    logic              fwd_hit;
    logic [31:0]       wb_sel_data;

    // Request/stall/abort outputs; reset gates them so they fall immediately.
    always_comb begin
        access     = EX_MEM_MemRead | EX_MEM_MemWrite;
        misaligned = access & (EX_MEM_ALUOut[1:0] != 2'b00);
        abort      = (state_q == WAIT) & (wait_cnt_q == MAX_CNT);
        req        = reset & access & ~misaligned & ~abort;
        stall      = req & ~dmem.ready;
    end

    // Store data bypass from the write-back register; $0 is never forwarded.
    always_comb begin
        fwd_hit = wb_we_q & (wb_addr_q != 5'd0) & (wb_addr_q == EX_MEM_Rt);
    end

    // Write-back source select: 01 memory, 10 link, 00/11 ALU result.
    always_comb begin
        case (EX_MEM_MemtoReg)
            2'b01:   wb_sel_data = dmem.rdata;
            2'b10:   wb_sel_data = EX_MEM_PC_add4;
            default: wb_sel_data = EX_MEM_ALUOut;
        endcase
    end

    // Next-state logic for the wait-state tracker.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (req && !dmem.ready) begin
                    state_d    = WAIT;
                    wait_cnt_d = CNT_ONE;
                end
            end
            WAIT: begin
                if (abort || !req || dmem.ready) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    // MEM/WB register and error flag next values: hold on stall, bubble on abort/misalign.
    always_comb begin
        mem_error_d = mem_error_q | misaligned | abort;
        wb_we_d     = wb_we_q;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        if (!stall) begin
            if (misaligned || abort) begin
                wb_we_d   = 1'b0;
                wb_addr_d = 5'd0;
                wb_data_d = 32'd0;
            end else begin
                wb_we_d   = EX_MEM_RegWrite;
                wb_addr_d = EX_MEM_RegWrAddr;
                wb_data_d = wb_sel_data;
            end
        end
    end

    // State, counter, sticky error and MEM/WB pipeline register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_addr_q   <= 5'd0;
            wb_data_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
            wb_we_q     <= wb_we_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
        end
    end

    assign dmem.req             = req;
    assign dmem.we              = reset & EX_MEM_MemWrite;
    assign dmem.addr            = EX_MEM_ALUOut;
    assign dmem.wdata           = fwd_hit ? wb_data_q : EX_MEM_WriteData;
    assign Mem_Stall            = stall;
    assign Mem_Error            = mem_error_q;
    assign MEM_WB_RegWrite      = wb_we_q;
    assign MEM_WB_RegWrAddr     = wb_addr_q;
    assign MEM_WB_WriteBackData = wb_data_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage (MAX_WAIT = 4). Inputs change on the
// falling edge; combinational outputs are sampled 1ns later and registered
// outputs 1ns after the rising edge.
module tb_mem_wb_stage;

    logic        clk;
    logic        reset;
    logic        mr, mw, rw;
    logic [1:0]  mtr;
    logic [31:0] alu, pc4, wd;
    logic [4:0]  rd, rt;
    logic        stall, err, wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int vecs;
    int errs;

    mem_wb_stage_if dmem_if ();

    mem_wb_stage #(.MAX_WAIT(4)) dut (
        .clk                  (clk),
        .reset                (reset),
        .EX_MEM_MemRead       (mr),
        .EX_MEM_MemWrite      (mw),
        .EX_MEM_MemtoReg      (mtr),
        .EX_MEM_RegWrite      (rw),
        .EX_MEM_ALUOut        (alu),
        .EX_MEM_PC_add4       (pc4),
        .EX_MEM_RegWrAddr     (rd),
        .EX_MEM_WriteData     (wd),
        .EX_MEM_Rt            (rt),
        .dmem                 (dmem_if.master),
        .Mem_Stall            (stall),
        .Mem_Error            (err),
        .MEM_WB_RegWrite      (wb_we),
        .MEM_WB_RegWrAddr     (wb_addr),
        .MEM_WB_WriteBackData (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_ex(input logic r, input logic w, input logic [1:0] sel, input logic we,
                          input logic [31:0] a, input logic [31:0] p, input logic [4:0] d,
                          input logic [31:0] sd, input logic [4:0] t);
        mr = r; mw = w; mtr = sel; rw = we; alu = a; pc4 = p; rd = d; wd = sd; rt = t;
    endtask

    task automatic set_nop();
        set_ex(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0, 5'd0);
        dmem_if.ready = 1'b0;
        dmem_if.rdata = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_nop();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        set_nop();
        reset = 1'b0;
        #1;
        vecs++;
        if ({wb_we, wb_addr, wb_data} !== 38'd0) begin
            errs++; $display("FAIL reset_mwb: got %h want 0", {wb_we, wb_addr, wb_data});
        end
        vecs++;
        if ({err, stall, dmem_if.req, dmem_if.we} !== 4'b0000) begin
            errs++; $display("FAIL reset_ctrl: got %b want 0000", {err, stall, dmem_if.req, dmem_if.we});
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        set_ex(1'b1, 1'b0, 2'b01, 1'b1, 32'h40, 32'd0, 5'd8, 32'd0, 5'd0);
        dmem_if.ready = 1'b1; dmem_if.rdata = 32'hDEADBEEF;
        #1;
        vecs++;
        if ({dmem_if.req, stall, dmem_if.addr} !== {1'b1, 1'b0, 32'h40}) begin
            errs++; $display("FAIL rmw_req: got %h want %h", {dmem_if.req, stall, dmem_if.addr}, {1'b1, 1'b0, 32'h40});
        end
        @(posedge clk); #1;
        vecs++;
        if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd8, 32'hDEADBEEF}) begin
            errs++; $display("FAIL rmw_wb: got %h want %h", {wb_we, wb_addr, wb_data}, {1'b1, 5'd8, 32'hDEADBEEF});
        end
        @(negedge clk);
        set_ex(1'b1, 1'b0, 2'b01, 1'b1, 32'h44, 32'd0, 5'd9, 32'd0, 5'd0);
        dmem_if.ready = 1'b0;
        @(negedge clk);
        #1;
        vecs++;
        if ({dmem_if.req, stall} !== 2'b11) begin
            errs++; $display("FAIL rmw_wait: got %b want 11", {dmem_if.req, stall});
        end
        reset = 1'b0;
        #1;
        vecs++;
        if ({dmem_if.req, stall, dmem_if.we} !== 3'b000) begin
            errs++; $display("FAIL rmw_rst_ctrl: got %b want 000", {dmem_if.req, stall, dmem_if.we});
        end
        vecs++;
        if ({wb_we, wb_addr, wb_data} !== 38'd0) begin
            errs++; $display("FAIL rmw_rst_mwb: got %h want 0", {wb_we, wb_addr, wb_data});
        end
        @(negedge clk);
        set_nop();
        reset = 1'b1;
    endtask

    task automatic test_wait_states();
        do_reset();
        set_ex(1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'd0, 5'd3, 32'd0, 5'd0);
        dmem_if.ready = 1'b1; dmem_if.rdata = 32'h11111111;
        @(negedge clk);
        set_ex(1'b1, 1'b0, 2'b01, 1'b1, 32'h20, 32'd0, 5'd4, 32'd0, 5'd0);
        dmem_if.ready = 1'b0; dmem_if.rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vecs++;
            if (stall !== 1'b1) begin
                errs++; $display("FAIL ws_stall%0d: got %b want 1", i, stall);
            end
            vecs++;
            if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd3, 32'h11111111}) begin
                errs++; $display("FAIL ws_hold%0d: got %h want %h", i, {wb_we, wb_addr, wb_data}, {1'b1, 5'd3, 32'h11111111});
            end
            @(negedge clk);
        end
        dmem_if.ready = 1'b1; dmem_if.rdata = 32'h22222222;
        #1;
        vecs++;
        if (stall !== 1'b0) begin
            errs++; $display("FAIL ws_ready_stall: got %b want 0", stall);
        end
        @(posedge clk); #1;
        vecs++;
        if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd4, 32'h22222222}) begin
            errs++; $display("FAIL ws_update: got %h want %h", {wb_we, wb_addr, wb_data}, {1'b1, 5'd4, 32'h22222222});
        end
        @(negedge clk);
        set_ex(1'b1, 1'b0, 2'b01, 1'b1, 32'h24, 32'd0, 5'd5, 32'd0, 5'd0);
        dmem_if.ready = 1'b1; dmem_if.rdata = 32'h33333333;
        #1;
        vecs++;
        if ({dmem_if.req, stall} !== 2'b10) begin
            errs++; $display("FAIL ws_idle_again: got %b want 10", {dmem_if.req, stall});
        end
        @(posedge clk); #1;
        vecs++;
        if (wb_data !== 32'h33333333) begin
            errs++; $display("FAIL ws_b2b: got %h want 33333333", wb_data);
        end
        @(negedge clk);
        set_nop();
    endtask

    task automatic test_timeout();
        do_reset();
        set_ex(1'b1, 1'b0, 2'b01, 1'b1, 32'h0, 32'd0, 5'd6, 32'd0, 5'd0);
        dmem_if.ready = 1'b1; dmem_if.rdata = 32'h66;
        @(negedge clk);
        set_ex(1'b0, 1'b1, 2'b00, 1'b0, 32'h80, 32'd0, 5'd0, 32'h77, 5'd2);
        dmem_if.ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            vecs++;
            if ({dmem_if.req, dmem_if.we, stall} !== 3'b111) begin
                errs++; $display("FAIL to_stall%0d: got %b want 111", i, {dmem_if.req, dmem_if.we, stall});
            end
            @(negedge clk);
        end
        dmem_if.ready = 1'b1;
        #1;
        vecs++;
        if ({dmem_if.req, stall, err} !== 3'b000) begin
            errs++; $display("FAIL to_abort: got %b want 000", {dmem_if.req, stall, err});
        end
        @(posedge clk); #1;
        vecs++;
        if ({err, wb_we, wb_addr, wb_data} !== 39'h40_0000_0000) begin
            errs++; $display("FAIL to_bubble: got %h want %h", {err, wb_we, wb_addr, wb_data}, 39'h40_0000_0000);
        end
        @(negedge clk);
        set_ex(1'b1, 1'b0, 2'b01, 1'b1, 32'h8, 32'd0, 5'd5, 32'd0, 5'd0);
        dmem_if.ready = 1'b1; dmem_if.rdata = 32'h55;
        @(posedge clk); #1;
        vecs++;
        if ({err, wb_we, wb_addr, wb_data} !== {1'b1, 1'b1, 5'd5, 32'h55}) begin
            errs++; $display("FAIL to_sticky: got %h want %h", {err, wb_we, wb_addr, wb_data}, {1'b1, 1'b1, 5'd5, 32'h55});
        end
        @(negedge clk);
        set_nop();
    endtask

    task automatic test_misaligned();
        do_reset();
        set_ex(1'b1, 1'b0, 2'b01, 1'b1, 32'h4, 32'd0, 5'd6, 32'd0, 5'd0);
        dmem_if.ready = 1'b1; dmem_if.rdata = 32'h66;
        @(negedge clk);
        set_ex(1'b1, 1'b0, 2'b01, 1'b1, 32'h42, 32'd0, 5'd7, 32'd0, 5'd0);
        #1;
        vecs++;
        if ({dmem_if.req, stall, err} !== 3'b000) begin
            errs++; $display("FAIL mis_req: got %b want 000", {dmem_if.req, stall, err});
        end
        @(posedge clk); #1;
        vecs++;
        if ({err, wb_we, wb_addr, wb_data} !== 39'h40_0000_0000) begin
            errs++; $display("FAIL mis_bubble: got %h want %h", {err, wb_we, wb_addr, wb_data}, 39'h40_0000_0000);
        end
        @(negedge clk);
        set_nop();
    endtask

    task automatic test_store_forwarding();
        do_reset();
        set_ex(1'b1, 1'b0, 2'b01, 1'b1, 32'h100, 32'd0, 5'd9, 32'd0, 5'd0);
        dmem_if.ready = 1'b1; dmem_if.rdata = 32'h1234;
        @(negedge clk);
        set_ex(1'b0, 1'b1, 2'b00, 1'b0, 32'h104, 32'd0, 5'd0, 32'hAAAA, 5'd9);
        #1;
        vecs++;
        if ({dmem_if.req, dmem_if.we, dmem_if.wdata} !== {1'b1, 1'b1, 32'h1234}) begin
            errs++; $display("FAIL fwd_basic: got %h want %h", {dmem_if.req, dmem_if.we, dmem_if.wdata}, {1'b1, 1'b1, 32'h1234});
        end
        @(negedge clk);
        set_ex(1'b1, 1'b0, 2'b01, 1'b1, 32'h100, 32'd0, 5'd9, 32'd0, 5'd0);
        @(negedge clk);
        set_ex(1'b0, 1'b1, 2'b00, 1'b0, 32'h104, 32'd0, 5'd0, 32'hAAAA, 5'd9);
        dmem_if.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) dmem_if.ready = 1'b1;
            #1;
            vecs++;
            if ({stall, dmem_if.wdata} !== {(i != 2), 32'h1234}) begin
                errs++; $display("FAIL fwd_stall%0d: got %h want %h", i, {stall, dmem_if.wdata}, {(i != 2), 32'h1234});
            end
            @(negedge clk);
        end
        set_ex(1'b1, 1'b0, 2'b01, 1'b1, 32'h108, 32'd0, 5'd0, 32'd0, 5'd0);
        dmem_if.ready = 1'b1; dmem_if.rdata = 32'h1234;
        @(negedge clk);
        set_ex(1'b0, 1'b1, 2'b00, 1'b0, 32'h10C, 32'd0, 5'd0, 32'hAAAA, 5'd0);
        #1;
        vecs++;
        if (dmem_if.wdata !== 32'hAAAA) begin
            errs++; $display("FAIL fwd_r0: got %h want 0000aaaa", dmem_if.wdata);
        end
        @(negedge clk);
        set_nop();
    endtask

    task automatic test_non_memory();
        do_reset();
        set_ex(1'b0, 1'b0, 2'b10, 1'b1, 32'h3, 32'h0040_0010, 5'd31, 32'd0, 5'd0);
        #1;
        vecs++;
        if ({dmem_if.req, stall} !== 2'b00) begin
            errs++; $display("FAIL jal_req: got %b want 00", {dmem_if.req, stall});
        end
        @(posedge clk); #1;
        vecs++;
        if ({err, wb_we, wb_addr, wb_data} !== {1'b0, 1'b1, 5'd31, 32'h0040_0010}) begin
            errs++; $display("FAIL jal_wb: got %h want %h", {err, wb_we, wb_addr, wb_data}, {1'b0, 1'b1, 5'd31, 32'h0040_0010});
        end
        @(negedge clk);
        set_ex(1'b0, 1'b0, 2'b11, 1'b1, 32'hCAFEF00D, 32'h0040_0020, 5'd12, 32'd0, 5'd0);
        @(posedge clk); #1;
        vecs++;
        if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd12, 32'hCAFEF00D}) begin
            errs++; $display("FAIL alu11_wb: got %h want %h", {wb_we, wb_addr, wb_data}, {1'b1, 5'd12, 32'hCAFEF00D});
        end
        @(negedge clk);
        set_ex(1'b0, 1'b0, 2'b00, 1'b1, 32'h0BADF00D, 32'h0040_0030, 5'd13, 32'd0, 5'd0);
        @(posedge clk); #1;
        vecs++;
        if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd13, 32'h0BADF00D}) begin
            errs++; $display("FAIL alu00_wb: got %h want %h", {wb_we, wb_addr, wb_data}, {1'b1, 5'd13, 32'h0BADF00D});
        end
        @(negedge clk);
        set_nop();
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_reset_mid_wait();
        test_wait_states();
        test_timeout();
        test_misaligned();
        test_store_forwarding();
        test_non_memory();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register. Consumes the EX/MEM register outputs, drives the data-memory request/ready port, and produces the write-back triple (enable, address, data) for the register file. It also handles the following:
- stalls the pipeline while memory is not ready;
- forwards write-back data to store data;
- aborts misaligned or timed-out accesses with a sticky error flag.

## Interface
- MAX_WAIT, 15: stall cycles allowed per access before abort; legal range ≥1.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- EX_MEM_MemRead  in  1  load in MEM
- EX_MEM_MemWrite  in  1  store in MEM
- EX_MEM_MemtoReg  in  2  write-back select: 00 ALU, 01 memory, 10 PC+4, 11 ALU
- EX_MEM_RegWrite  in  1  instruction writes a register
- EX_MEM_ALUOut  in  32  ALU result / memory address
- EX_MEM_PC_add4  in  32  link value
- EX_MEM_RegWrAddr  in  5  destination register
- EX_MEM_WriteData  in  32  store data (rt value)
- EX_MEM_Rt  in  5  store source register
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned byte address
- dmem_wdata  out  32  store data after forwarding
- dmem_ready  in  1  access completes this cycle
- dmem_rdata  in  32  load data, valid when dmem_ready
- Mem_Stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM this cycle
- Mem_Error  out  1  sticky: misaligned or timed-out access seen
- MEM_WB_RegWrite  out  1  write-back enable
- MEM_WB_RegWrAddr  out  5  write-back register
- MEM_WB_WriteBackData  out  32  write-back data

## Operation

**Access decode**
- access = MemRead | MemWrite.
- misaligned = access & (ALUOut[1:0] != 0).
- MemWrite set with MemRead also set is treated as a store.

**Request outputs**
- dmem_req = access & !misaligned & !abort.
- dmem_addr = ALUOut.
- dmem_we = MemWrite.
- All request outputs are combinational from the EX/MEM inputs and state.

**Store forwarding**
- dmem_wdata = MEM_WB_WriteBackData if MEM_WB_RegWrite & MEM_WB_RegWrAddr != 0 & MEM_WB_RegWrAddr == EX_MEM_Rt.
- Otherwise dmem_wdata = EX_MEM_WriteData.

**State machine**
- States: IDLE, WAIT. 5-bit-or-wider counter wait_cnt (width clog2(MAX_WAIT+1)).
- IDLE, dmem_req & dmem_ready: completes; no stall; stay IDLE.
- IDLE, dmem_req & !dmem_ready: Mem_Stall=1; go to WAIT; wait_cnt←1.
- WAIT, dmem_ready: completes; Mem_Stall=0; go to IDLE; wait_cnt←0.
- WAIT, !dmem_ready & wait_cnt < MAX_WAIT: Mem_Stall=1; wait_cnt++.
- WAIT, !dmem_ready & wait_cnt == MAX_WAIT: abort=1; dmem_req=0; Mem_Stall=0; Mem_Error←1; go to IDLE; wait_cnt←0.
- Misaligned in IDLE: no request; Mem_Stall=0; Mem_Error←1.

**Write-back data**
- MemtoReg 01 selects dmem_rdata, 10 selects PC_add4, 00 and 11 select ALUOut.

**MEM/WB register (each rising edge)**
- Mem_Stall=1: hold all three outputs. Re-writing the same register is harmless, and holding keeps store forwarding valid across the stall.
- Misaligned or abort: load bubble (RegWrite=0, RegWrAddr=0, data=0).
- Otherwise: load RegWrite, RegWrAddr and the selected write-back data.
- A store loads RegWrite from EX/MEM; it is 0 for stores by decode.

**Error flag**
- Mem_Error is cleared only by reset.

## Timing

**Reset (reset low, asynchronous)**
- All outputs 0: MEM_WB_*, Mem_Error, Mem_Stall, dmem_req, dmem_we.
- State IDLE, wait_cnt 0.
- dmem_req drops immediately, even mid-WAIT. The aborted access is not retried.

**Latency and stalls**
- Zero-wait access: MEM_WB_* reflect the instruction one edge after it is present on the EX_MEM_* inputs.
- N wait cycles (N < MAX_WAIT): Mem_Stall high exactly N cycles; MEM_WB updates on the edge closing the ready cycle.
- Timeout: Mem_Stall high exactly MAX_WAIT cycles, then one abort cycle with Mem_Stall=0. The bubble and Mem_Error=1 are visible after that edge.
- dmem_ready in the abort cycle is ignored, because dmem_req is 0 there.
- dmem_ready while dmem_req=0 is ignored.

**Back-to-back and hazards**
- Back-to-back accesses: a new request may issue in the cycle after completion, with no dead cycle.
- Mem_Stall depends combinationally on dmem_ready. Upstream must not feed Mem_Stall back into dmem_ready.

## Test plan
- **Reset mid-wait:** after reset release, load addr 0x40 with MemtoReg=01, RegWrAddr=8, dmem_ready=1 with rdata 0xDEADBEEF → dmem_req high one cycle, no stall; next edge MEM_WB = {1, 8, 0xDEADBEEF}. Then assert reset low during WAIT → dmem_req, Mem_Stall and MEM_WB_* go 0 immediately.
- **Wait states:** load with ready delayed 3 cycles → Mem_Stall high 3 cycles; MEM_WB holds its previous value, then updates on the ready-cycle edge; state back to IDLE.
- **Timeout:** MAX_WAIT=4, store with ready never asserted → Mem_Stall high 4 cycles, abort cycle with dmem_req=0; after that edge Mem_Error=1 and MEM_WB_RegWrite=0. Mem_Error stays 1 through later good accesses.
- **Misalignment:** load at addr 0x42 → no dmem_req, no stall, Mem_Error=1, bubble in MEM/WB.
- **Store forwarding:** lw $9 (rdata 0x1234) followed by sw with Rt=9 and EX_MEM_WriteData=0xAAAA → dmem_wdata=0x1234. The same case with a 2-cycle stall on the sw keeps dmem_wdata=0x1234 throughout. With Rt=0 → 0xAAAA.
- **Non-memory write-back:** jal (MemtoReg=10, PC_add4=0x0040_0010, RegWrAddr=31) → no dmem_req; MEM_WB={1, 31, 0x0040_0010}. ALU op with MemtoReg=11 → ALUOut written.
